// File: rtl/fpu_norm_pipe.sv
// fpu_norm_pipe: two-stage normaliser for FPU ALU results (carry shift, leading-zero shift,
// overflow/underflow/zero flags) with a valid/ready handshake on both sides.
module fpu_norm_pipe #(
    parameter int EXP_W     = 8,
    parameter int MANT_W    = 28,
    parameter int DENORM_EN = 0,
    parameter int TAG_W     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    input  logic              i_carry,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_zero
);
    localparam int LZ_W = $clog2(MANT_W);

    logic              r_v1, r_c1, r_v2, r_ovf2, r_unf2, r_zero2;
    logic [EXP_W-1:0]  r_exp1, r_exp2;
    logic [MANT_W-1:0] r_mant1, r_mant2;
    logic [TAG_W-1:0]  r_tag1, r_tag2;
    logic [LZ_W-1:0]   r_lz1, w_lz;
    logic              w_en1, w_en2, w_zero, w_ovf, w_unf;
    logic [EXP_W-1:0]  w_inc, w_sh, w_exp;
    logic [MANT_W-1:0] w_mant;

    assign w_en2   = ~r_v2 | i_ready;
    assign w_en1   = ~r_v1 | w_en2;
    assign o_ready = w_en1;
    assign o_valid = r_v2;

    // Ascending scan: the highest set bit is the last to write, so it sets the count.
    always_comb begin
        w_lz = LZ_W'(MANT_W - 1);
        for (int i = 0; i < MANT_W; i++)
            if (i_mant[i]) w_lz = LZ_W'(MANT_W - 1 - i);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1    <= 1'b0;
            r_c1    <= 1'b0;
            r_exp1  <= '0;
            r_mant1 <= '0;
            r_tag1  <= '0;
            r_lz1   <= '0;
        end else if (w_en1) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_c1    <= i_carry;
                r_exp1  <= i_exp;
                r_mant1 <= i_mant;
                r_tag1  <= i_tag;
                r_lz1   <= w_lz;
            end
        end
    end

    always_comb begin
        w_inc  = r_exp1 + EXP_W'(1);
        w_zero = ~r_c1 & ~|r_mant1;
        w_ovf  = r_c1 & (&w_inc);
        w_unf  = ~r_c1 & ~w_zero & (32'(r_lz1) >= 32'(r_exp1));
        w_sh   = (r_exp1 == '0) ? '0 : r_exp1 - EXP_W'(1);
        w_exp  = r_c1 ? w_inc : (w_zero | w_unf) ? '0 : r_exp1 - EXP_W'(r_lz1);
        w_mant = (w_ovf | w_zero) ? '0 :
                 r_c1  ? {1'b1, r_mant1[MANT_W-1:2], |r_mant1[1:0]} :
                 w_unf ? ((DENORM_EN != 0) ? r_mant1 << w_sh : '0) :
                         r_mant1 << r_lz1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v2    <= 1'b0;
            r_exp2  <= '0;
            r_mant2 <= '0;
            r_tag2  <= '0;
            r_ovf2  <= 1'b0;
            r_unf2  <= 1'b0;
            r_zero2 <= 1'b0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_exp2  <= w_exp;
                r_mant2 <= w_mant;
                r_tag2  <= r_tag1;
                r_ovf2  <= w_ovf;
                r_unf2  <= w_unf;
                r_zero2 <= w_zero;
            end
        end
    end

    assign o_exp       = r_exp2;
    assign o_mant      = r_mant2;
    assign o_tag       = r_tag2;
    assign o_overflow  = r_ovf2;
    assign o_underflow = r_unf2;
    assign o_zero      = r_zero2;
endmodule

// File: tb/tb_fpu_norm_pipe.sv
// tb_fpu_norm_pipe: directed + random scoreboard bench for fpu_norm_pipe, flush and subnormal builds.
module tb_fpu_norm_pipe;
    logic        clk = 1'b0, rst_n = 1'b1, i_valid = 1'b0, i_carry = 1'b0, i_ready = 1'b1;
    logic [7:0]  i_exp = '0;
    logic [27:0] i_mant = '0;
    logic [3:0]  i_tag = '0;
    logic        o_ready, o_valid, o_ovf, o_unf, o_zero;
    logic [7:0]  o_exp;
    logic [27:0] o_mant;
    logic [3:0]  o_tag;
    logic        d_ready, d_valid, d_ovf, d_unf, d_zero;
    logic [7:0]  d_exp;
    logic [27:0] d_mant;
    logic [3:0]  d_tag;
    int          total = 0, bad = 0, n_acc = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [7:0]  e;
        logic [27:0] m, m_dn;
        logic        ovf, unf, zero;
    } res_t;
    res_t q[$];

    always #5 clk = ~clk;

    fpu_norm_pipe #(.DENORM_EN(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_exp(i_exp), .i_mant(i_mant), .i_carry(i_carry), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_exp(o_exp), .o_mant(o_mant), .o_tag(o_tag),
        .o_overflow(o_ovf), .o_underflow(o_unf), .o_zero(o_zero)
    );

    fpu_norm_pipe #(.DENORM_EN(1)) u_dn (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(d_ready),
        .i_exp(i_exp), .i_mant(i_mant), .i_carry(i_carry), .i_tag(i_tag),
        .o_valid(d_valid), .i_ready(i_ready), .o_exp(d_exp), .o_mant(d_mant), .o_tag(d_tag),
        .o_overflow(d_ovf), .o_underflow(d_unf), .o_zero(d_zero)
    );

    function automatic res_t model(logic [7:0] e, logic [27:0] m, logic c, logic [3:0] t);
        res_t r;
        int   lz;
        r = '{tag: t, e: 8'h00, m: 28'h0, m_dn: 28'h0, ovf: 1'b0, unf: 1'b0, zero: 1'b0};
        if (c) begin
            if (8'(e + 8'd1) == 8'hFF) begin
                r.e   = 8'hFF;
                r.ovf = 1'b1;
            end else begin
                r.e    = 8'(e + 8'd1);
                r.m    = (m >> 1) | 28'h8000000 | {27'h0, m[0]};
                r.m_dn = r.m;
            end
        end else if (m == 28'h0) begin
            r.zero = 1'b1;
        end else begin
            lz = 0;
            while (!m[27 - lz]) lz++;
            if (lz < int'(e)) begin
                r.e    = 8'(int'(e) - lz);
                r.m    = m << lz;
                r.m_dn = r.m;
            end else begin
                r.unf  = 1'b1;
                r.m_dn = m << ((e == 8'h00) ? 0 : int'(e) - 1);
            end
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] obs, logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, obs, want);
        end
    endtask

    task automatic drive(logic [7:0] e, logic [27:0] m, logic c, logic [3:0] t);
        int k;
        i_valid = 1'b1; i_exp = e; i_mant = m; i_carry = c; i_tag = t;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_ready) begin
                q.push_back(model(e, m, c, t));
                n_acc++;
                break;
            end
        end
        if (k == 20) chk("accept_timeout", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    res_t held, x;
    bit   stalled = 1'b0;
    always @(negedge clk) begin
        if (rst_n && o_valid && !i_ready) begin
            if (stalled) begin
                chk("hold_tag", 64'(o_tag), 64'(held.tag));
                chk("hold_mant", 64'(o_mant), 64'(held.m));
                chk("hold_exp", 64'(o_exp), 64'(held.e));
            end
            stalled = 1'b1;
            held = '{tag: o_tag, e: o_exp, m: o_mant, m_dn: d_mant, ovf: o_ovf, unf: o_unf, zero: o_zero};
        end else stalled = 1'b0;
        if (rst_n && o_valid && i_ready) begin
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL extra_result: got tag %0h want no result", o_tag);
            end
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("tag", 64'(o_tag), 64'(x.tag));
                chk("exp", 64'(o_exp), 64'(x.e));
                chk("mant", 64'(o_mant), 64'(x.m));
                chk("flags", 64'({o_ovf, o_unf, o_zero}), 64'({x.ovf, x.unf, x.zero}));
                chk("dn_valid", 64'(d_valid), 64'd1);
                chk("dn_exp", 64'(d_exp), 64'(x.e));
                chk("dn_mant", 64'(d_mant), 64'(x.m_dn));
                chk("dn_flags", 64'({d_ovf, d_unf, d_zero}), 64'({x.ovf, x.unf, x.zero}));
            end
        end
    end

    initial begin
        int base;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_outs", 64'({o_exp, o_mant, o_tag, o_ovf, o_unf, o_zero}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(8'h80, 28'h0000003, 1'b1, 4'h1);
        @(negedge clk); chk("lat_cycle1", 64'(o_valid), 64'd0);
        @(negedge clk); chk("lat_cycle2", 64'(o_valid), 64'd1);
        @(posedge clk); #1;
        drive(8'hFE, 28'h1234567, 1'b1, 4'h2);
        drive(8'h80, 28'h0100000, 1'b0, 4'h3);
        drive(8'h03, 28'h0000010, 1'b0, 4'h4);
        drive(8'h55, 28'h0000000, 1'b0, 4'h5);
        drive(8'h07, 28'h0100000, 1'b0, 4'h6);
        drive(8'h08, 28'h0100000, 1'b0, 4'h7);
        drive(8'h00, 28'h0000005, 1'b0, 4'h8);
        drive(8'h10, 28'hFFFFFFF, 1'b0, 4'h9);
        drive(8'h01, 28'h8000000, 1'b0, 4'hA);
        for (int i = 0; i < 12; i++)
            drive(8'($urandom_range(0, 255)), 28'($urandom >> $urandom_range(4, 31)),
                  1'($urandom_range(0, 1)), 4'(i));
        repeat (4) @(posedge clk); #1;
        base = n_acc;
        fork
            begin
                drive(8'h40, 28'h0000100, 1'b0, 4'hB);
                drive(8'h41, 28'h0000200, 1'b0, 4'hC);
                drive(8'h42, 28'h0000400, 1'b1, 4'hD);
                drive(8'h43, 28'h0000800, 1'b0, 4'hE);
            end
            begin
                i_ready = 1'b0;
                repeat (4) @(negedge clk);
                chk("bp_accepted", 64'(n_acc - base), 64'd2);
                chk("bp_ready_low", 64'(o_ready), 64'd0);
                @(posedge clk); #1;
                i_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        drive(8'h20, 28'h0001000, 1'b0, 4'h1);
        drive(8'h21, 28'h0002000, 1'b0, 4'h2);
        drive(8'h22, 28'h0004000, 1'b0, 4'h3);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_ready", 64'(o_ready), 64'd1);
        chk("midrst_tag", 64'(o_tag), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(8'h30, 28'h0000001, 1'b0, 4'hF);
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL drain: got %0d pending want 0", q.size());
        end
        repeat (6) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
